// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback handshakes from the ALU and load paths plus the register-file write port
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              idle;
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, writeReg, writeData, regWrite, idle
  );
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, writeReg, writeData, regWrite, idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin scheduling of ALU and load writebacks onto one register-file write port
module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                   clock_in,
  input logic                   reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic {GRANT_A, GRANT_M} grant_t;
  grant_t            last_grant, last_grant_next;
  logic [1:0]        valid, ready, push, pop, nonempty;
  logic [ADDR_W-1:0] req_reg [2];
  logic [DATA_W-1:0] req_data [2];
  logic [EW-1:0]     head [2];
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  assign valid       = {bus.mem_valid, bus.alu_valid};
  assign req_reg[0]  = bus.alu_reg;
  assign req_reg[1]  = bus.mem_reg;
  assign req_data[0] = bus.alu_data;
  assign req_data[1] = bus.mem_data;
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] count;
    assign ready[s]    = count != CW'(DEPTH);
    assign nonempty[s] = count != '0;
    // register 0 completes the handshake but is never queued
    assign push[s]     = valid[s] && ready[s] && req_reg[s] != '0;
    assign head[s]     = mem[rd];
    always_ff @(posedge clock_in)
      if (push[s]) mem[wr] <= {req_reg[s], req_data[s]};
    always_ff @(posedge clock_in or negedge reset_n)
      if (!reset_n) begin
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (push[s]) wr <= wr + 1'b1;
        if (pop[s]) rd <= rd + 1'b1;
        count <= count + CW'(push[s]) - CW'(pop[s]);
      end
  end
  always_comb begin
    pop             = '0;
    pop[0]          = nonempty[0] && (!nonempty[1] || last_grant == GRANT_M);
    pop[1]          = nonempty[1] && !pop[0];
    last_grant_next = pop[0] ? GRANT_A : pop[1] ? GRANT_M : last_grant;
  end
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      last_grant <= GRANT_M;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      last_grant <= last_grant_next;
      reg_write  <= |pop;
      if (|pop) {write_reg, write_data} <= pop[0] ? head[0] : head[1];
    end
  assign bus.alu_ready = ready[0];
  assign bus.mem_ready = ready[1];
  assign bus.writeReg  = write_reg;
  assign bus.writeData = write_data;
  assign bus.regWrite  = reg_write;
  assign bus.idle      = !nonempty[0] && !nonempty[1] && !reg_write;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus hand sequences for streaming and mid-operation reset
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_write_arbiter #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          rst;
    logic        av;
    logic [4:0]  areg;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mreg;
    logic [31:0] mdata;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ar;
    logic        mr;
    logic        idle;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic av, logic [4:0] ar, logic [31:0] ad, logic mv, logic [4:0] mr, logic [31:0] md);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask
  task automatic chk_out(string tag, int idx, logic rw, logic [4:0] wr, logic [31:0] wd, logic ar, logic mr, logic idle);
    chk({tag, " regWrite"}, idx, 32'(bus.regWrite), 32'(rw));
    chk({tag, " writeReg"}, idx, 32'(bus.writeReg), 32'(wr));
    chk({tag, " writeData"}, idx, bus.writeData, wd);
    chk({tag, " alu_ready"}, idx, 32'(bus.alu_ready), 32'(ar));
    chk({tag, " mem_ready"}, idx, 32'(bus.mem_ready), 32'(mr));
    chk({tag, " idle"}, idx, 32'(bus.idle), 32'(idle));
  endtask
  initial begin
    // tie on the first cycle after reset goes to A, then M
    vecs.push_back('{1, 1, 10, 32'h0000FFFF, 1, 21, 32'h12345678, 0, 0,  32'h0,        1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 10, 32'h0000FFFF, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 21, 32'h12345678, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 21, 32'h12345678, 1, 1, 1});
    // single A write: visible one edge after the push, for one cycle
    vecs.push_back('{0, 1, 21, 32'hFFFF0000, 0, 0,  32'h0,        0, 21, 32'h12345678, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 21, 32'hFFFF0000, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 21, 32'hFFFF0000, 1, 1, 1});
    // register 0 is accepted and dropped
    vecs.push_back('{0, 1, 0,  32'hDEADBEEF, 0, 0,  32'h0,        0, 21, 32'hFFFF0000, 1, 1, 1});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 21, 32'hFFFF0000, 1, 1, 1});
    // both backlogged: senders hold their request while ready is low
    vecs.push_back('{1, 1, 1,  32'hA0000000, 1, 16, 32'hB0000000, 0, 0,  32'h0,        1, 1, 0});
    vecs.push_back('{0, 1, 2,  32'hA0000001, 1, 17, 32'hB0000001, 1, 1,  32'hA0000000, 1, 0, 0});
    vecs.push_back('{0, 1, 3,  32'hA0000002, 1, 18, 32'hB0000002, 1, 16, 32'hB0000000, 0, 1, 0});
    vecs.push_back('{0, 1, 4,  32'hA0000003, 1, 18, 32'hB0000002, 1, 2,  32'hA0000001, 1, 0, 0});
    vecs.push_back('{0, 1, 4,  32'hA0000003, 1, 19, 32'hB0000003, 1, 17, 32'hB0000001, 0, 1, 0});
    vecs.push_back('{0, 1, 5,  32'hA0000004, 1, 19, 32'hB0000003, 1, 3,  32'hA0000002, 1, 0, 0});
    vecs.push_back('{0, 1, 5,  32'hA0000004, 1, 20, 32'hB0000004, 1, 18, 32'hB0000002, 0, 1, 0});
    vecs.push_back('{0, 1, 6,  32'hA0000005, 1, 20, 32'hB0000004, 1, 4,  32'hA0000003, 1, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 19, 32'hB0000003, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 5,  32'hA0000004, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 20, 32'hB0000004, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 20, 32'hB0000004, 1, 1, 1});
    do_reset();
    chk_out("reset", 0, 0, 0, 32'h0, 1, 1, 1);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].av, vecs[i].areg, vecs[i].adata, vecs[i].mv, vecs[i].mreg, vecs[i].mdata);
      tick();
      chk_out("vec", i, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].ar, vecs[i].mr, vecs[i].idle);
    end
    // A streams alone: push and pop overlap, order is kept, ready never drops
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(8 + i), 32'hC0000000 + 32'(i), 0, 0, 0);
      tick();
      if (i == 0) chk_out("stream", i, 0, 0, 32'h0, 1, 1, 0);
      else chk_out("stream", i, 1, 5'(7 + i), 32'hC0000000 + 32'(i - 1), 1, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("stream", 4, 1, 11, 32'hC0000003, 1, 1, 0);
    tick();
    chk_out("stream", 5, 0, 11, 32'hC0000003, 1, 1, 1);
    // asynchronous reset with entries queued and a write in flight
    do_reset();
    drive(1, 1, 32'hD0000000, 1, 16, 32'hE0000000);
    tick();
    drive(1, 2, 32'hD0000001, 1, 17, 32'hE0000001);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("pre_rst", 0, 1, 1, 32'hD0000000, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 32'h0, 1, 1, 1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("post_rst", i, 0, 0, 32'h0, 1, 1, 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
